// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID-stage hazard, flush, FP sequencing and STOP drain controller.
// Optional macro HAZARD_FP_STALL_EN: when defined, ADDF/MULTF stall the front end
// for their latency in FP_WAIT; when undefined they behave as single-cycle ops.
module pipe_hazard_ctrl #(
    parameter int OP_WIDTH     = 4,
    parameter int RA_WIDTH     = 4,
    parameter int FP_ADD_LAT   = 2,
    parameter int FP_MUL_LAT   = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OP_WIDTH-1:0] id_opcode_i,
    input  logic [RA_WIDTH-1:0] id_rs_i,
    input  logic [RA_WIDTH-1:0] id_rt_i,
    input  logic                ex_MemRead_i,
    input  logic [RA_WIDTH-1:0] ex_rd_i,
    input  logic                ex_branch_taken_i,
    output logic                pc_write_o,
    output logic                ifid_write_o,
    output logic                idex_bubble_o,
    output logic                ifid_flush_o,
    output logic                fp_start_o,
    output logic                fp_busy_o,
    output logic                halted_o
);
    localparam logic [OP_WIDTH-1:0] OP_STOP  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_ADDF  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_MULTF = OP_WIDTH'(9);

    typedef enum logic [1:0] {RUN, FP_WAIT, DRAIN, HALT} state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, fp_lat;
    logic                 load_use, is_stop, is_fp;

    // r0 is hardwired zero, so a load targeting it never feeds a dependent op
    assign load_use = ex_MemRead_i && ex_rd_i != '0 && (ex_rd_i == id_rs_i || ex_rd_i == id_rt_i);
    assign is_stop  = id_opcode_i == OP_STOP;
    assign is_fp    = id_opcode_i == OP_ADDF || id_opcode_i == OP_MULTF;
    assign fp_lat   = id_opcode_i == OP_MULTF ? CNT_WIDTH'(FP_MUL_LAT) : CNT_WIDTH'(FP_ADD_LAT);

    // state and countdown register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // next state: STOP/FP only launch once branch and load-use have been cleared
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (!ex_branch_taken_i && !load_use) begin
                    if (is_stop) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = CNT_WIDTH'(DRAIN_CYCLES);
                    end else if (is_fp) begin
                        cnt_nxt   = fp_lat;
`ifdef HAZARD_FP_STALL_EN
                        state_nxt = FP_WAIT;
`endif
                    end
                end
            end
            FP_WAIT, DRAIN: begin
                cnt_nxt = cnt - CNT_WIDTH'(1);
                if (cnt == CNT_WIDTH'(1))
                    state_nxt = state == FP_WAIT ? RUN : HALT;
            end
            default: ;
        endcase
    end

    // outputs: reset forces the stalled/bubble vector even before the clock sees it
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
        ifid_flush_o  = 1'b0;
        fp_start_o    = 1'b0;
        fp_busy_o     = 1'b0;
        halted_o      = 1'b0;
        if (!rst_i) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken_i) begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                        ifid_flush_o = 1'b1;
                    end else if (!load_use) begin
                        pc_write_o    = 1'b1;
                        ifid_write_o  = 1'b1;
                        idex_bubble_o = 1'b0;
                        fp_start_o    = is_fp;
                    end
                end
`ifdef HAZARD_FP_STALL_EN
                FP_WAIT: fp_busy_o = 1'b1;
`endif
                HALT: halted_o = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with directed and randomized stimulus.
module tb_pipe_hazard_ctrl;
    localparam int ADD_LAT = 2;
    localparam int MUL_LAT = 4;
    localparam int DRAIN   = 3;
`ifdef HAZARD_FP_STALL_EN
    localparam bit FP_ON = 1'b1;
`else
    localparam bit FP_ON = 1'b0;
`endif
    localparam logic [3:0] NOP = 4'hF, ADD = 4'h2, STOP = 4'h7, ADDF = 4'h8, MULTF = 4'h9;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] id_opcode_i = NOP, id_rs_i = '0, id_rt_i = '0, ex_rd_i = '0;
    logic       ex_MemRead_i = 1'b0, ex_branch_taken_i = 1'b0;
    logic       pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, fp_start_o, fp_busy_o, halted_o;

    pipe_hazard_ctrl #(.OP_WIDTH(4), .RA_WIDTH(4), .FP_ADD_LAT(ADD_LAT), .FP_MUL_LAT(MUL_LAT),
                       .DRAIN_CYCLES(DRAIN), .CNT_WIDTH(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_opcode_i(id_opcode_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .ex_MemRead_i(ex_MemRead_i), .ex_rd_i(ex_rd_i), .ex_branch_taken_i(ex_branch_taken_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .idex_bubble_o(idex_bubble_o),
        .ifid_flush_o(ifid_flush_o), .fp_start_o(fp_start_o), .fp_busy_o(fp_busy_o), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    // expected vector order: {pc_write, ifid_write, bubble, flush, fp_start, fp_busy, halted}
    logic [6:0] exp_q[$];
    int         cyc_q[$];
    int         checks = 0, fails = 0, cyc = 0;
    int         fp_left = 0, drain_left = 0, halt_cycles = 0;
    bit         halted = 1'b0;
    logic [3:0] ops[10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hF};

    // reference model: remaining stall/drain cycles counted directly from the rules
    task automatic drive(input bit r, input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                         input bit mr, input logic [3:0] rd, input bit br);
        logic [6:0] e;
        bit         lu;
        @(negedge clk_i);
        rst_i = r; id_opcode_i = op; id_rs_i = rs; id_rt_i = rt;
        ex_MemRead_i = mr; ex_rd_i = rd; ex_branch_taken_i = br;
        lu = mr && rd != 0 && (rd == rs || rd == rt);
        if (r) begin
            e = 7'b0010000; fp_left = 0; drain_left = 0; halted = 1'b0;
        end else if (halted) begin
            e = 7'b0010001;
        end else if (drain_left > 0) begin
            e = 7'b0010000; drain_left--; halted = drain_left == 0;
        end else if (fp_left > 0) begin
            e = 7'b0010010; fp_left--;
        end else if (br) begin
            e = 7'b1111000;
        end else if (lu) begin
            e = 7'b0010000;
        end else begin
            e = 7'b1100000;
            if (op == STOP) drain_left = DRAIN;
            else if (op == ADDF || op == MULTF) begin
                e[2] = 1'b1;
                fp_left = FP_ON ? (op == MULTF ? MUL_LAT : ADD_LAT) : 0;
            end
        end
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(0, NOP, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    endtask

    // monitor: compares the DUT against the oldest pending expectation each cycle
    initial forever begin
        logic [6:0] e, got;
        int         c;
        @(negedge clk_i);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            got = {pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, fp_start_o, fp_busy_o, halted_o};
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL outputs cycle %0d: got %b expected %b", c, got, e);
            end
        end
    end

    initial begin
        drive(1, NOP, 0, 0, 0, 0, 0);
        drive(1, ADD, 3, 3, 1, 3, 1);
        // load-use stall, then retry; rd=0 gives no stall
        drive(0, ADD, 3, 1, 1, 3, 0);
        drive(0, ADD, 3, 1, 0, 0, 0);
        drive(0, ADD, 0, 1, 1, 0, 0);
        drive(0, ADD, 2, 4, 1, 4, 0);
        // branch beats load-use
        drive(0, ADD, 3, 1, 1, 3, 1);
        // MULTF and ADDF latency, branch ignored during wait
        drive(0, MULTF, 1, 2, 0, 0, 0);
        idle(6);
        drive(0, ADDF, 1, 2, 0, 0, 0);
        idle(4);
        // load-use with MULTF in ID: stall, then start
        drive(0, MULTF, 2, 5, 1, 5, 0);
        drive(0, MULTF, 2, 5, 0, 0, 0);
        idle(6);
        // reset in the middle of a MULTF wait
        drive(0, MULTF, 1, 1, 0, 0, 0);
        idle(2);
        drive(1, MULTF, 1, 1, 0, 0, 0);
        drive(0, NOP, 0, 0, 0, 0, 0);
        idle(2);
        // randomized traffic with occasional STOP and reset
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] op;
            bit         r;
            op = ops[$urandom_range(0, 9)];
            if (op == STOP && $urandom_range(0, 7) != 0) op = NOP;
            halt_cycles = halted ? halt_cycles + 1 : 0;
            r = $urandom_range(0, 199) == 0 || halt_cycles > 25;
            drive(r, op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                  4'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
        end
        // STOP drain then a held halt regardless of inputs
        drive(1, NOP, 0, 0, 0, 0, 0);
        drive(0, STOP, 1, 2, 0, 0, 0);
        idle(24);
        drive(1, NOP, 0, 0, 0, 0, 0);
        drive(0, ADD, 1, 2, 0, 0, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 16-bit pipelined processor. It sits beside the ID stage and watches the opcode in ID, the load in EX and the JMPZ outcome. It generates PC/IF-ID write enables, ID/EX bubble insertion and IF-ID flush. It also sequences multi-cycle ADDF/MULTF operations and drains the pipeline to a permanent halt on STOP.

## Interface
- OP_WIDTH, 4, opcode width
- RA_WIDTH, 4, register address width
- FP_ADD_LAT, 2, ADDF execute cycles (1..2^CNT_WIDTH-1)
- FP_MUL_LAT, 4, MULTF execute cycles (1..2^CNT_WIDTH-1)
- DRAIN_CYCLES, 3, bubbles inserted after STOP before halt (EX, MEM, WB)
- CNT_WIDTH, 3, cycle counter width; must hold max(FP_ADD_LAT, FP_MUL_LAT, DRAIN_CYCLES)

Ports:
- clk_i  in  1  clock, rising edge; the block has one clock
- rst_i  in  1  asynchronous, active-high reset
- id_opcode_i  in  OP_WIDTH  opcode in ID (ADD=0010, SW=0001, LW=0000, SUB=0100, MOV=0011, JMPZ=0101, STOP=0111, ADDF=1000, MULTF=1001, NOP=1111)
- id_rs_i, id_rt_i  in  RA_WIDTH  ID source registers
- ex_MemRead_i  in  1  EX instruction is a load
- ex_rd_i  in  RA_WIDTH  EX destination register
- ex_branch_taken_i  in  1  JMPZ in EX resolved taken
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID register load enable
- idex_bubble_o  out  1  load NOP control vector into ID/EX
- ifid_flush_o  out  1  clear IF/ID to NOP
- fp_start_o  out  1  one-cycle start pulse to FP unit
- fp_busy_o  out  1  FP operation in progress
- halted_o  out  1  processor halted

## Operation
- FSM states: RUN, FP_WAIT, DRAIN, HALT. The block also holds a CNT_WIDTH down-counter `cnt`.
- Outputs are combinational from the state and the inputs.
- While rst_i=1: state=RUN, cnt=0, pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0, fp_start_o=0, fp_busy_o=0, halted_o=0.
- RUN, evaluated in strict priority order (first match wins):
  1. Branch taken (ex_branch_taken_i=1): ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1. The ID opcode is wrong-path and is ignored.
  2. Load-use hazard (ex_MemRead_i=1, ex_rd_i≠0, and ex_rd_i equals id_rs_i or id_rt_i): pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. State stays RUN.
  3. STOP in ID: instruction advances normally, cnt←DRAIN_CYCLES, next state DRAIN.
  4. ADDF/MULTF in ID: fp_start_o=1, instruction advances, cnt←FP_ADD_LAT or FP_MUL_LAT, next state FP_WAIT.
  5. Otherwise: pc_write_o=1, ifid_write_o=1, all other outputs 0.
- FP_WAIT:
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, fp_busy_o=1.
  - cnt decrements each cycle; when cnt==1, next state is RUN.
  - ex_branch_taken_i is ignored, because EX holds the FP instruction.
- DRAIN:
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - cnt decrements each cycle; when cnt==1, next state is HALT.
  - All inputs are ignored.
- HALT:
  - halted_o=1, pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - Exit only by reset.
- Register 0 never creates a load-use hazard.

## Timing
- Load-use stall: exactly 1 cycle. The same ID instruction re-evaluates next cycle; the EX stage now holds the bubble.
- FP: start pulse in cycle T. FP_WAIT for cycles T+1..T+LAT, giving LAT stall cycles. RUN again at T+LAT+1.
- STOP in ID at T: DRAIN for cycles T+1..T+DRAIN_CYCLES. halted_o=1 from T+DRAIN_CYCLES+1.
- Simultaneous events:
  - Branch + load-use: flush only, no stall.
  - Load-use + FP/STOP in ID: stall first; start or drain is taken on the retry cycle.
- Reset mid-FP_WAIT or mid-DRAIN: immediate return to the reset outputs. No fp_start_o is reissued.

## Configuration
- HAZARD_FP_STALL_EN defined: FP_WAIT sequencing as above.
- HAZARD_FP_STALL_EN undefined:
  - ADDF/MULTF are treated as single-cycle. fp_start_o still pulses for one cycle, but the state stays RUN.
  - fp_busy_o is tied 0 and FP_WAIT is unreachable.

## Test plan
- LW r3 in EX, ADD r3 in ID → exactly one cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. Same with rd=0 → no stall.
- JMPZ taken in EX while LW-dependent ADD in ID → ifid_flush_o=1 and idex_bubble_o=1 for 1 cycle, pc_write_o=1, no stall.
- MULTF in ID (FP_MUL_LAT=4) → fp_start_o pulse at T, fp_busy_o=1 and pc_write_o=0 at T+1..T+4, RUN at T+5. ADDF (lat 2) → RUN at T+3. Without HAZARD_FP_STALL_EN → no stall.
- STOP in ID at T → bubbles at T+1..T+3, halted_o=1 from T+4 and held 20 cycles regardless of inputs.
- Assert rst_i asynchronously at T+2 of a MULTF wait → outputs take reset values the same cycle. After release, state is RUN with pc_write_o=1.
- Load-use with MULTF in ID → 1 stall cycle, then fp_start_o on the following cycle.
